// File: rtl/id_scan_arbiter.sv
// id_scan_arbiter: round-robin grant of whole character strings from two requesters into a
// letter-then-digit hit counter, with one registered result per string over valid/ready.
module id_scan_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [7:0]       req_char0,
  input  logic [7:0]       req_char1,
  input  logic [1:0]       req_last,
  output logic [1:0]       req_ready,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [CNT_W-1:0] res_hits,
  output logic [CNT_W-1:0] res_len
);
  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;
  state_t state;
  logic gnt, last_gnt, flag, flag_nx, letter, digit, acc;
  logic [7:0] ch;
  logic [CNT_W-1:0] hits, len, hits_nx, len_nx;
  assign ch = gnt ? req_char1 : req_char0;
  assign letter = (ch >= 8'h41 && ch <= 8'h5a) || (ch >= 8'h61 && ch <= 8'h7a);
  assign digit = ch >= 8'h30 && ch <= 8'h39;
  assign acc = state == RUN && req_valid[gnt];
  // a hit needs an unbroken letter-led run; digits neither set nor clear the flag
  assign flag_nx = letter || (digit && flag);
  assign hits_nx = (digit && flag && !(&hits)) ? hits + CNT_W'(1) : hits;
  assign len_nx = &len ? len : len + CNT_W'(1);
  assign req_ready = state == RUN ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= 1'b0;
      last_gnt <= 1'b1;
      flag <= 1'b0;
      hits <= '0;
      len <= '0;
      res_valid <= 1'b0;
      res_id <= 1'b0;
      res_hits <= '0;
      res_len <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          gnt <= &req_valid ? ~last_gnt : req_valid[1];
          hits <= '0;
          len <= '0;
          flag <= 1'b0;
          state <= RUN;
        end
        RUN: if (acc) begin
          hits <= hits_nx;
          len <= len_nx;
          flag <= flag_nx;
          if (req_last[gnt]) begin
            res_valid <= 1'b1;
            res_id <= gnt;
            res_hits <= hits_nx;
            res_len <= len_nx;
            state <= REPORT;
          end
        end
        REPORT: if (res_ready) begin
          res_valid <= 1'b0;
          last_gnt <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_id_scan_arbiter.sv
// tb_id_scan_arbiter: directed vectors for id_scan_arbiter; a CNT_W=2 copy shares the inputs.
module tb_id_scan_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, res_ready = 1'b0;
  logic [1:0] req_valid = '0, req_last = '0, req_ready, s_req_ready;
  logic [7:0] req_char0 = '0, req_char1 = '0;
  logic busy, res_valid, res_id, s_busy, s_res_valid, s_res_id, both_rdy = 1'b0;
  logic [7:0] res_hits, res_len;
  logic [1:0] s_hits, s_len;
  int checks = 0, errors = 0;
  id_scan_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_char0(req_char0),
    .req_char1(req_char1), .req_last(req_last), .req_ready(req_ready), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_hits(res_hits), .res_len(res_len));
  id_scan_arbiter #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_char0(req_char0),
    .req_char1(req_char1), .req_last(req_last), .req_ready(s_req_ready), .busy(s_busy),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_id(s_res_id),
    .res_hits(s_hits), .res_len(s_len));
  always #5 clk = ~clk;
  always @(negedge clk) if (req_ready == 2'b11) both_rdy = 1'b1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic send(input int r, input string s);
    for (int i = 0; i < s.len(); i++) begin
      int t = 0;
      if (r == 0) req_char0 = s[i]; else req_char1 = s[i];
      req_valid[r] = 1'b1;
      req_last[r] = i == s.len() - 1;
      while (!req_ready[r] && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("accept_timeout", 0, 1);
      @(negedge clk);
    end
    req_valid[r] = 1'b0;
    req_last[r] = 1'b0;
  endtask
  task automatic get_result(input int id, input int h, input int l);
    int t = 0;
    while (!res_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid", res_valid, 1);
    chk("res_id", res_id, id);
    chk("res_hits", res_hits, h);
    chk("res_len", res_len, l);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_clr", res_valid, 0);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_id", res_id, 0);
    chk("rst_hits", res_hits, 0);
    chk("rst_len", res_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, "a1");
    chk("latency", res_valid, 1);
    get_result(0, 1, 2);
    send(1, "1a2");  get_result(1, 1, 3);
    send(1, "12");   get_result(1, 0, 2);
    send(1, "ab 12"); get_result(1, 0, 5);
    send(1, "A9z8"); get_result(1, 2, 4);
    do_reset();
    fork
      begin send(0, "a1"); send(0, "b22"); end
      begin send(1, "c3"); send(1, "9z"); end
      begin
        get_result(0, 1, 2);
        get_result(1, 1, 2);
        get_result(0, 2, 3);
        get_result(1, 0, 2);
      end
    join
    send(1, "x"); get_result(1, 0, 1);
    send(1, "y"); get_result(1, 0, 1);
    chk("rdy_onehot", both_rdy, 0);
    req_valid[1] = 1'b1;
    req_char1 = "q";
    req_last[1] = 1'b1;
    send(0, "x");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_len", res_len, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    get_result(0, 0, 1);
    send(1, "q"); get_result(1, 0, 1);
    send(0, "a11111");
    chk("sat_hits", s_hits, 3);
    chk("sat_len", s_len, 3);
    get_result(0, 5, 6);
    req_valid = 2'b01;
    req_char0 = "a";
    req_last = 2'b00;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", req_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", res_valid, 0);
    @(negedge clk);
    req_valid = 2'b11;
    rst_n = 1'b1;
    @(negedge clk);
    chk("tie_after_rst", req_ready, 2'b01);
    req_valid = 2'b00;
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_scan_arbiter.md
Name: id_scan_arbiter

Overview:
- Two character-stream requesters share one identifier-scan engine.
- The block grants whole strings round-robin and feeds the granted stream into an internal letter/digit recognizer.
- It counts identifier-digit hits and string length per string, then reports one result per string over a valid/ready handshake.
- It sits between the character sources and the result consumer, and is the controller for the identifier FSM datapath.

Parameters:
CNT_W, 8, width of hit and length counters (both saturate at 2^CNT_W-1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-requester beat valid; bit i = requester i
req_char0  input  8  requester 0 ASCII character
req_char1  input  8  requester 1 ASCII character
req_last  input  2  per-requester end-of-string marker, qualifies the beat
req_ready  output  2  per-requester beat accept; at most one bit set
busy  output  1  high in RUN or REPORT
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_id  output  1  requester that produced the result
res_hits  output  CNT_W  hit count for the string
res_len  output  CNT_W  beats in the string

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE, req_ready=0, busy=0.
  - res_valid=0, res_id=0, res_hits=0, res_len=0.
  - Round-robin pointer last_gnt=1, so requester 0 wins the first tie.
  - Letter flag=0.
- Char classes:
  - Letter: 0x41-0x5A or 0x61-0x7A.
  - Digit: 0x30-0x39.
  - Other: everything else.
- FSM states: IDLE, RUN, REPORT.
- IDLE:
  - req_ready=00.
  - If any req_valid bit is set, grant at the next edge and go to RUN.
  - If both are set, grant !last_gnt; otherwise grant the single requester.
  - On grant: clear the length counter, hit counter and letter flag; register gnt.
- RUN:
  - req_ready[gnt]=1 combinationally from state; the other bit is 0.
  - A beat is accepted on a req_valid[gnt] & req_ready[gnt] edge. Per accepted beat:
    - len += 1, saturating.
    - Letter: flag <= 1.
    - Digit: if flag==1 then hits += 1, saturating; flag is unchanged.
    - Other: flag <= 0.
  - A digit with flag==0 leaves flag at 0; letter-first runs are required for a hit.
  - Accepted beat with req_last[gnt]=1: go to REPORT. The counters include that beat.
  - The non-granted requester's valid, last and char are ignored. It must hold its beat.
- REPORT:
  - res_valid=1; res_id=gnt; res_hits and res_len are the final counts.
  - All outputs are held stable while res_ready=0.
  - res_valid & res_ready edge: res_valid <= 0, last_gnt <= gnt, go to IDLE.
  - A new grant can occur at the earliest on the edge after returning to IDLE.
- Latency:
  - N-beat string with no stalls: grant edge, N accept edges, res_valid high the cycle after the last accept.
  - Minimum turnaround per string is N+2 cycles with res_ready held high.
- res_hits and res_len are registered. Between results they keep their last values; the consumer looks only at res_valid.
- busy = (state != IDLE).
- Boundaries:
  - 1-beat string: last is on the first beat; len=1.
  - Counter saturation holds at all-ones with no wrap.
  - req_valid deasserted mid-string in RUN: wait indefinitely with the grant kept.
  - rst_n low at any time, including mid-RUN or REPORT: immediate return to reset values. The partial string is discarded and no result is produced.

Test Plan:
- Single string, req0: 0x61, 0x31(last) -> grant 0; res_id=0, res_hits=1, res_len=2; res_valid rises 1 cycle after the last accept.
- Class rules, req1: "1a2" -> hits=1, len=3. "12" -> hits=0. "ab 12" -> hits=0 because the space clears the flag. "A9z8" -> hits=2, len=4.
- Arbitration after reset, both valid continuously with 2-beat strings -> results in the order id 0, 1, 0, 1. With only req1 valid twice -> 1, 1. The non-granted req_ready stays 0 throughout.
- Backpressure: hold res_ready=0 for 5 cycles in REPORT -> res_valid=1 and values stable; req_ready=00; no second grant until the handshake completes.
- Saturation with CNT_W=2: "a11111"(last) -> res_hits=3, res_len=3.
- Reset mid-RUN after 2 accepted beats: rst_n low asynchronously -> req_ready=00, busy=0, res_valid=0 at once. After release, the first tie is won by requester 0.
